// File: rtl/uart_proto_pkg.sv
// Shared definitions for the RX/ALU command protocol and its TX companion.
// Holds the frame tag constants and the default field widths.
package uart_proto_pkg;

   // Default widths used across the command protocol
   localparam int NB_DATA_DEF = 8;
   localparam int NB_OP_DEF   = 6;

   // Frame tags (same field width as the operation code)
   localparam logic [NB_OP_DEF-1:0] DATOA  = 6'b001000;
   localparam logic [NB_OP_DEF-1:0] DATOB  = 6'b010000;
   localparam logic [NB_OP_DEF-1:0] OP     = 6'b100000;
   localparam logic [NB_OP_DEF-1:0] RESULT = 6'b000100;

endpackage : uart_proto_pkg

// File: rtl/uart_result_sender_tx_watchdog.sv
// Watchdog for one UART byte hand-over. The counter is cleared while a
// byte is being loaded, counts while waiting for the TX done bit, and
// saturates at the limit. o_expire flags the wait cycle on whose closing
// edge the counter reaches limit-1, so the owner can abort the frame on
// that same edge.
module tx_watchdog #(
   parameter int NB_TOUT = 16
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_clear,
   input  logic               i_enable,
   input  logic [NB_TOUT-1:0] i_limit,
   output logic               o_expire
);

   logic [NB_TOUT-1:0] r_count;
   logic [NB_TOUT-1:0] w_threshold;

   // Expiry threshold: the count value seen one cycle before limit-1 is reached
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a value on
      // every path (here via the default first), otherwise a latch is inferred.
      w_threshold = '0;
      if (i_limit > NB_TOUT'(2)) begin
         w_threshold = i_limit - NB_TOUT'(2);
      end
   end

   assign o_expire = i_enable && (r_count >= w_threshold);

   // Wait-cycle counter: clear on load, count while enabled, hold at the limit
   always_ff @(posedge clk or negedge i_rst_n) begin
      // NOTE: state is updated with non-blocking assignments so every register
      // samples values from before the edge, independent of statement order.
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != i_limit)) begin
         r_count <= r_count + NB_TOUT'(1);
      end
   end

endmodule : tx_watchdog

// File: rtl/uart_result_sender.sv
// Sends an ALU result to UART_TX as a two-byte frame: a tag byte marking
// a result, then the result byte. Each byte is handed over with a
// one-cycle start pulse and the block waits for the TX done bit; a
// watchdog aborts the frame if done never arrives.
module uart_result_sender
   import uart_proto_pkg::*;
#(
   parameter int                 NB_DATA     = NB_DATA_DEF,
   parameter int                 NB_OP       = NB_OP_DEF,
   parameter logic [NB_OP-1:0]   RESULT_TAG  = RESULT,
   parameter int                 NB_TOUT     = 16,
   parameter logic [NB_TOUT-1:0] TOUT_CYCLES = 16'd50000
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_txDone,
   output logic               o_tx_start,
   output logic [NB_DATA-1:0] o_data,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_overrun,
   output logic               o_timeout
);

   // Header byte: result tag zero-extended to a full byte
   localparam logic [NB_DATA-1:0] HEADER = {{(NB_DATA-NB_OP){1'b0}}, RESULT_TAG};

   // One-hot frame sequencer encoding
   typedef enum logic [4:0] {
      S_IDLE     = 5'b00001,
      S_HDR_LOAD = 5'b00010,
      S_HDR_WAIT = 5'b00100,
      S_DAT_LOAD = 5'b01000,
      S_DAT_WAIT = 5'b10000
   } state_e;

   state_e             r_state;
   state_e             w_state_nxt;

   logic [NB_DATA-1:0] r_res;
   logic [NB_DATA-1:0] r_data;
   logic               r_tx_start;
   logic               r_done;
   logic               r_overrun;
   logic               r_timeout;

   logic               w_is_idle;
   logic               w_is_load;
   logic               w_is_wait;
   logic               w_expire;
   logic               w_capture;
   logic               w_tx_start_nxt;
   logic [NB_DATA-1:0] w_data_nxt;
   logic               w_done_nxt;
   logic               w_overrun_nxt;
   logic               w_timeout_nxt;

   assign w_is_idle = (r_state == S_IDLE);
   assign w_is_load = (r_state == S_HDR_LOAD) || (r_state == S_DAT_LOAD);
   assign w_is_wait = (r_state == S_HDR_WAIT) || (r_state == S_DAT_WAIT);

   tx_watchdog #(
      .NB_TOUT (NB_TOUT)
   ) u_watchdog (
      .clk      (clk),
      .i_rst_n  (i_rst_n),
      .i_clear  (w_is_load),
      .i_enable (w_is_wait),
      .i_limit  (TOUT_CYCLES),
      .o_expire (w_expire)
   );

   // State register
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; TX done beats watchdog expiry in the wait states
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt = S_HDR_LOAD;
            end
         end
         S_HDR_LOAD: begin
            w_state_nxt = S_HDR_WAIT;
         end
         S_HDR_WAIT: begin
            if (i_txDone) begin
               w_state_nxt = S_DAT_LOAD;
            end else if (w_expire) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_DAT_LOAD: begin
            w_state_nxt = S_DAT_WAIT;
         end
         S_DAT_WAIT: begin
            if (i_txDone || w_expire) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Output decode: next values of the registered outputs, so the start
   // pulse and byte are visible during the LOAD state itself
   always_comb begin
      w_capture      = w_is_idle && i_start;
      w_tx_start_nxt = 1'b0;
      w_data_nxt     = r_data;
      if (w_state_nxt == S_HDR_LOAD) begin
         w_tx_start_nxt = 1'b1;
         w_data_nxt     = HEADER;
      end else if (w_state_nxt == S_DAT_LOAD) begin
         w_tx_start_nxt = 1'b1;
         w_data_nxt     = r_res;
      end
      w_done_nxt    = (r_state == S_DAT_WAIT) && i_txDone;
      w_overrun_nxt = !w_is_idle && i_start;
      w_timeout_nxt = w_is_wait && !i_txDone && w_expire;
   end

   // Result capture and registered outputs
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_res      <= '0;
         r_data     <= '0;
         r_tx_start <= 1'b0;
         r_done     <= 1'b0;
         r_overrun  <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_capture) begin
            r_res <= i_result;
         end
         r_data     <= w_data_nxt;
         r_tx_start <= w_tx_start_nxt;
         r_done     <= w_done_nxt;
         r_overrun  <= w_overrun_nxt;
         r_timeout  <= w_timeout_nxt;
      end
   end

   assign o_tx_start = r_tx_start;
   assign o_data     = r_data;
   assign o_busy     = !w_is_idle;
   assign o_done     = r_done;
   assign o_overrun  = r_overrun;
   assign o_timeout  = r_timeout;

endmodule : uart_result_sender

// File: tb/tb_uart_result_sender.sv
// Directed bench for uart_result_sender with a short watchdog (8 cycles).
// Expected TX bytes are queued when a frame is requested and popped when
// the DUT pulses o_tx_start. A small TX model can return i_txDone a fixed
// number of cycles after each o_tx_start.
module tb_uart_result_sender;

   localparam int NB_DATA = 8;
   localparam int TOUT    = 8;
   localparam int DLY     = 5;
   localparam logic [7:0] HDR = 8'h04;

   logic               clk = 1'b0;
   logic               i_rst_n;
   logic               i_start;
   logic [NB_DATA-1:0] i_result;
   logic               i_txDone;
   logic               o_tx_start;
   logic [NB_DATA-1:0] o_data;
   logic               o_busy;
   logic               o_done;
   logic               o_overrun;
   logic               o_timeout;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int resp_delay = 0;
   int resp_cnt   = 0;
   int n_done = 0;
   int n_ovr  = 0;
   int n_tout = 0;
   int cyc;

   always #5 clk = ~clk;

   uart_result_sender #(
      .NB_DATA     (NB_DATA),
      .TOUT_CYCLES (16'(TOUT))
   ) dut (
      .clk        (clk),
      .i_rst_n    (i_rst_n),
      .i_start    (i_start),
      .i_result   (i_result),
      .i_txDone   (i_txDone),
      .o_tx_start (o_tx_start),
      .o_data     (o_data),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_overrun  (o_overrun),
      .o_timeout  (o_timeout)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Per-cycle observer: pulse counts, byte scoreboard, TX done model
   task automatic monitor();
      logic [7:0] e;
      if (o_done)    n_done++;
      if (o_overrun) n_ovr++;
      if (o_timeout) n_tout++;
      if (o_tx_start) begin
         if (exp_q.size() == 0) begin
            check("tx_start_unexpected", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("tx_byte", 32'(o_data), 32'(e));
         end
      end
      if (resp_delay > 0) begin
         i_txDone = 1'b0;
         if (o_tx_start) begin
            resp_cnt = resp_delay;
         end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) i_txDone = 1'b1;
         end
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled at the falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      monitor();
   endtask

   task automatic request(input logic [7:0] res);
      i_start  = 1'b1;
      i_result = res;
      exp_q.push_back(HDR);
      exp_q.push_back(res);
   endtask

   task automatic wait_done(input int budget, output int cycles);
      cycles = 0;
      for (int i = 0; i < budget; i++) begin
         tick();
         cycles++;
         if (o_done) break;
      end
      check("done_seen", 32'(o_done), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1, "time limit");
   end

   initial begin
      i_rst_n  = 1'b0;
      i_start  = 1'b0;
      i_result = '0;
      i_txDone = 1'b0;
      repeat (3) tick();

      // Reset state
      check("rst_tx_start", 32'(o_tx_start), 32'd0);
      check("rst_data",     32'(o_data),     32'd0);
      check("rst_busy",     32'(o_busy),     32'd0);
      check("rst_flags",    {29'd0, o_done, o_overrun, o_timeout}, 32'd0);
      i_rst_n = 1'b1;
      repeat (6) tick();

      // Basic frame, TX model answers 5 cycles after each start pulse
      resp_delay = DLY;
      request(8'hA5);
      tick();
      i_start = 1'b0;
      check("t1_hdr_start", 32'(o_tx_start), 32'd1);
      check("t1_hdr_data",  32'(o_data),     32'(HDR));
      check("t1_busy",      32'(o_busy),     32'd1);
      tick();
      check("t1_start_1cyc", 32'(o_tx_start), 32'd0);
      wait_done(40, cyc);
      check("t1_latency",   32'(cyc + 2), 32'(1 + 2 * (DLY + 1)));
      check("t1_busy_drop", 32'(o_busy),  32'd0);
      tick();
      check("t1_done_1cyc", 32'(o_done),  32'd0);
      check("t1_data_hold", 32'(o_data),  32'hA5);

      // Overrun while waiting for the header byte
      request(8'h3C);
      tick();
      i_start = 1'b0;
      tick();
      i_start  = 1'b1;
      i_result = 8'hFF;
      tick();
      i_start = 1'b0;
      check("t2_overrun",      32'(o_overrun), 32'd1);
      tick();
      check("t2_overrun_1cyc", 32'(o_overrun), 32'd0);
      wait_done(40, cyc);
      check("t2_queue", 32'(exp_q.size()), 32'd0);

      // Watchdog abort: TX never answers
      resp_delay = 0;
      i_txDone   = 1'b0;
      i_start    = 1'b1;
      i_result   = 8'h5A;
      exp_q.push_back(HDR);
      tick();
      i_start = 1'b0;
      check("t3_hdr_start", 32'(o_tx_start), 32'd1);
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         cyc++;
         if (o_timeout) break;
      end
      check("t3_timeout_seen", 32'(o_timeout), 32'd1);
      check("t3_timeout_lat",  32'(cyc),       32'(TOUT));
      check("t3_busy_drop",    32'(o_busy),    32'd0);
      repeat (4) tick();
      check("t3_idle",  32'(o_busy),        32'd0);
      check("t3_tout",  32'(n_tout),        32'd1);
      check("t3_queue", 32'(exp_q.size()),  32'd0);

      // TX done on the exact expiry cycle of the data wait
      request(8'h77);
      tick();
      i_start = 1'b0;
      tick();
      i_txDone = 1'b1;
      tick();
      i_txDone = 1'b0;
      check("t4_dat_start", 32'(o_tx_start), 32'd1);
      check("t4_dat_data",  32'(o_data),     32'h77);
      repeat (7) tick();
      i_txDone = 1'b1;
      tick();
      i_txDone = 1'b0;
      check("t4_done",    32'(o_done),    32'd1);
      check("t4_no_tout", 32'(o_timeout), 32'd0);
      check("t4_busy",    32'(o_busy),    32'd0);
      tick();
      check("t4_no_tout_late", 32'(o_timeout), 32'd0);

      // Reset in the data wait, then a normal frame
      resp_delay = DLY;
      request(8'h99);
      tick();
      i_start = 1'b0;
      repeat (7) tick();
      check("t5_in_frame", 32'(o_busy), 32'd1);
      i_rst_n = 1'b0;
      #1;
      check("t5_rst_outs", {22'd0, o_data, o_tx_start, o_busy, o_done, o_overrun, o_timeout}, 32'd0);
      resp_cnt = 0;
      i_txDone = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
      request(8'h11);
      tick();
      i_start = 1'b0;
      wait_done(40, cyc);
      check("t5_queue", 32'(exp_q.size()), 32'd0);

      // Stray TX done in IDLE and during the header load
      resp_delay = 0;
      i_txDone   = 1'b1;
      tick();
      i_txDone = 1'b0;
      check("t6_idle_busy",  32'(o_busy),     32'd0);
      check("t6_idle_start", 32'(o_tx_start), 32'd0);
      check("t6_idle_done",  32'(o_done),     32'd0);
      request(8'h22);
      tick();
      i_start  = 1'b0;
      i_txDone = 1'b1;
      tick();
      i_txDone = 1'b0;
      check("t6_load_ignore", 32'(o_tx_start), 32'd0);
      check("t6_load_busy",   32'(o_busy),     32'd1);
      tick();
      i_txDone = 1'b1;
      tick();
      check("t6_dat_start", 32'(o_tx_start), 32'd1);
      check("t6_dat_data",  32'(o_data),     32'h22);
      tick();
      i_txDone = 1'b0;
      check("t6_datload_ignore", 32'(o_done), 32'd0);
      tick();
      i_txDone = 1'b1;
      tick();
      i_txDone = 1'b0;
      check("t6_done", 32'(o_done), 32'd1);
      tick();

      // Totals over the whole run
      check("end_queue", 32'(exp_q.size()), 32'd0);
      check("end_done",  32'(n_done), 32'd5);
      check("end_ovr",   32'(n_ovr),  32'd1);
      check("end_tout",  32'(n_tout), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_uart_result_sender

// File: doc/uart_result_sender.md
# uart_result_sender

Transmit-side companion to the RX/ALU command parser. On a start pulse it captures the ALU result and sends it to the UART_TX module as a two-byte frame: a tag byte identifying a result, then the result byte. Each byte is handed over with a one-cycle start pulse, and the block waits for the TX done bit before continuing. A watchdog aborts the frame if TX never reports done.

## Interface
Parameters:
- `NB_DATA`, 8, data/byte width.
- `NB_OP`, 6, tag field width (same width as the operation field in the command protocol).
- `RESULT_TAG`, 6'b000100, tag for result frames. The header byte is `{ {NB_DATA-NB_OP{1'b0}}, RESULT_TAG }`, i.e. 8'h04.
- `NB_TOUT`, 16, watchdog counter width.
- `TOUT_CYCLES`, 16'd50000, number of wait cycles without `i_txDone` before the frame is aborted.

Ports:
- `clk`  in  1  project clock. One clock; reset is asynchronous and active-low.
- `i_rst_n`  in  1  asynchronous active-low reset.
- `i_start`  in  1  request to send a result (the command parser's tx start).
- `i_result`  in  NB_DATA  ALU result, sampled when `i_start` is accepted.
- `i_txDone`  in  1  UART_TX done bit; single-cycle pulse per byte.
- `o_tx_start`  out  1  one-cycle pulse to UART_TX.
- `o_data`  out  NB_DATA  byte presented to UART_TX (registered).
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse when the frame completes.
- `o_overrun`  out  1  one-cycle pulse when `i_start` arrives while busy.
- `o_timeout`  out  1  one-cycle pulse when the watchdog aborts a frame.

## Operation
- States: IDLE, HDR_LOAD, HDR_WAIT, DAT_LOAD, DAT_WAIT.
- **IDLE**: `i_start`=1 captures `i_result` into `res_q` and moves to HDR_LOAD. `i_txDone` is ignored.
- **HDR_LOAD** (1 cycle):
  - `o_tx_start`=1 and `o_data`=header (both registered outputs, so visible during this state).
  - Clear the watchdog, then go to HDR_WAIT.
- **HDR_WAIT**:
  - `i_txDone`=1 moves to DAT_LOAD.
  - Otherwise the watchdog increments. When it reaches `TOUT_CYCLES-1` without `i_txDone`, pulse `o_timeout` and go to IDLE.
- **DAT_LOAD** (1 cycle): `o_tx_start`=1 and `o_data`=`res_q`; clear the watchdog; go to DAT_WAIT.
- **DAT_WAIT**:
  - `i_txDone`=1 pulses `o_done` and returns to IDLE.
  - Watchdog behaviour is the same as in HDR_WAIT.
- `o_busy`=1 in every state except IDLE.
- `i_start` in any non-IDLE state:
  - Pulse `o_overrun`.
  - The request is discarded; `res_q` is unchanged.
  - This includes the cycle in which the final `i_txDone` is sampled.
- `i_txDone` during a LOAD state is ignored.
- If `i_txDone` and watchdog expiry coincide in a WAIT state, `i_txDone` wins and no `o_timeout` is produced.
- `o_data` holds the last loaded byte until the next LOAD; it is not cleared in IDLE.
- Reset values: state=IDLE, `res_q`=0, watchdog=0, and all outputs 0 (`o_data`=0, `o_tx_start`=0, `o_busy`=0, `o_done`=0, `o_overrun`=0, `o_timeout`=0).
- Reset mid-frame aborts immediately with no pulses. Any in-flight UART byte is the TX module's concern.

## Timing
- `i_start` sampled high in cycle N:
  - N+1: `o_tx_start`=1, `o_data`=8'h04, `o_busy`=1.
  - N+2: `o_tx_start`=0.
- `i_txDone` sampled in HDR_WAIT in cycle M:
  - M+1: `o_tx_start`=1, `o_data`=result.
- `i_txDone` sampled in DAT_WAIT in cycle K:
  - K+1: `o_done`=1, `o_busy`=0.
  - A new `i_start` is accepted from K+1.
- Minimum frame occupancy is 4 cycles (with `i_txDone` on the first WAIT cycle).
- Watchdog: with no `i_txDone`, `o_timeout` is asserted `TOUT_CYCLES` cycles after the LOAD cycle, and `o_busy` drops on the same cycle.
- `o_done`, `o_overrun` and `o_timeout` are registered, exactly one cycle wide.

## Structure
- Shared package `uart_proto_pkg`:
  - tag constants DATOA=6'b001000, DATOB=6'b010000, OP=6'b100000, RESULT=6'b000100;
  - `NB_DATA`/`NB_OP` defaults.
- This block's state encoding stays local (one-hot, 5 bits).
- One natural sub-module: `tx_watchdog`. It takes clear, enable and limit inputs and produces an expire output. It holds the `NB_TOUT` counter, saturating at the limit.

## Test plan
- `i_result`=8'hA5 with `i_start` at cycle 10; TX bench returns `i_txDone` 5 cycles after each `o_tx_start` -> `o_tx_start` at 11 with `o_data`=8'h04, then `o_data`=8'hA5 on the second `o_tx_start`; `o_done` once; `o_busy` high from 11 until `o_done`.
- `i_start` with `i_result`=8'h3C, then `i_start` again with 8'hFF while in HDR_WAIT -> one `o_overrun` pulse; frame still sends 8'h04, 8'h3C.
- `TOUT_CYCLES`=8, `i_txDone` never asserted -> `o_timeout` 8 cycles after the header `o_tx_start`; no data byte is sent; IDLE afterwards.
- `TOUT_CYCLES`=8, `i_txDone` on the exact expiry cycle in DAT_WAIT -> `o_done`=1 and `o_timeout`=0.
- Reset asserted in DAT_WAIT -> all outputs 0 immediately. After release, a new `i_start` with 8'h11 sends 8'h04, 8'h11 normally.
- `i_txDone` pulses while IDLE and during HDR_LOAD -> no state change, no spurious `o_tx_start` or `o_done`.
